// File: rtl/adc_sar_driver_pkg.sv
// Shared state encoding and sizing constants
// for the SAR ADC driver and its result FIFO.
package adc_sar_driver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_EOC,
    CAPTURE,
    GAP
  } state_t;

  // Guard bits let up to 8 full-scale samples sum without wrap.
  localparam int ACC_GUARD = 3;
  localparam int CNT_W = 3;

  function automatic int acc_w(input int n);
    return n + ACC_GUARD;
  endfunction

endpackage

// File: rtl/adc_sar_driver_fifo.sv
// Result FIFO: head is combinational, data reads 0 when empty.
// DEPTH must be a power of two so pointers wrap naturally.
module adc_sar_driver_fifo
  import adc_sar_driver_pkg::*;
#(
  parameter int N = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [N-1:0]               wdata,
  output logic [N-1:0]               data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_pop;
  logic          do_push;

  assign valid   = count != '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign data    = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adc_sar_driver.sv
// SAR ADC sequencer: soc/eoc handshake, 2^k averaging,
// free-run gap timer and a result FIFO with sticky overflow.
module adc_sar_driver
  import adc_sar_driver_pkg::*;
#(
  parameter int N = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         continuous,
  input  logic [1:0]   avg_sel,
  input  logic [7:0]   period,
  input  logic         trig,
  input  logic         clr_ovf,
  output logic         soc,
  input  logic         eoc,
  input  logic         eoc_it,
  input  logic [N-1:0] dout,
  output logic [N-1:0] data,
  output logic         valid,
  input  logic         pop,
  output logic         busy,
  output logic         done_it,
  output logic         overflow
);

  localparam int AW = acc_w(N);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] ONE = 1;

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [1:0]       avg_q;
  logic [7:0]       gap_cnt;
  logic             last;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic [N-1:0]     res;
  logic [CW-1:0]    fifo_count;

  assign acc_sum = acc + AW'(dout);
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign last    = cnt_inc == (ONE << avg_q);
  assign res     = N'(acc_sum >> avg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (trig || continuous) state_nx = START;
        START:
          state_nx = WAIT_BUSY;
        WAIT_BUSY:
          if (!eoc) state_nx = WAIT_EOC;
        WAIT_EOC:
          if (eoc_it) state_nx = CAPTURE;
        CAPTURE:
          if (!last) state_nx = START;
          else if (!continuous) state_nx = IDLE;
          else if (period != 8'd0) state_nx = GAP;
          else state_nx = START;
        GAP:
          if (!continuous) state_nx = IDLE;
          else if (gap_cnt == 8'd0) state_nx = START;
        default:
          state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    soc  = 1'b0;
    busy = 1'b1;
    push = 1'b0;
    unique case (state)
      IDLE:             busy = 1'b0;
      START, WAIT_BUSY: soc = 1'b1;
      CAPTURE:          push = enable && last;
      default:          ;
    endcase
  end

  assign done_it = push;

  always_ff @(posedge clk) begin
    if (rst) begin
      avg_q <= '0;
    end else if (state == IDLE && state_nx == START) begin
      avg_q <= avg_sel;
    end
  end

  // Gap counter is preloaded to period-1 so GAP lasts period cycles.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      acc     <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        CAPTURE:
          if (last) begin
            acc     <= '0;
            cnt     <= '0;
            gap_cnt <= period - 8'd1;
          end else begin
            acc <= acc_sum;
            cnt <= cnt_inc[CNT_W-1:0];
          end
        GAP:
          if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so only push-while-full-without-pop drops.
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  adc_sar_driver_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (res),
    .data  (data),
    .valid (valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  cnt_bound: assert property (
    @(posedge clk) disable iff (rst) fifo_count <= CW'(DEPTH)
  );

endmodule

// File: tb/tb_adc_sar_driver.sv
// Bench for adc_sar_driver: ADC responder, averaging/FIFO
// scoreboard checked every cycle, plus directed scenarios.
module tb_adc_sar_driver;

  localparam int N = 8;
  localparam int DEPTH = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst, enable, continuous, trig, clr_ovf, pop;
  logic [1:0] avg_sel;
  logic [7:0] period;
  logic soc, eoc, eoc_it, valid, busy, done_it, overflow;
  logic [N-1:0] dout, data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] adc_q[$];
  bit adc_busy = 0;
  int lat = 0;

  logic [N-1:0] mq[$];
  bit m_ovf = 0;
  bit m_prev_it = 0;
  bit live = 1;
  bit chk_on = 0;
  int msum = 0;
  int mcnt = 0;
  int mavg = 0;

  int soc_rises = 0;
  int done_cnt = 0;
  logic soc_q = 1'b0;
  int s0, d0;

  always #5 clk = ~clk;

  adc_sar_driver #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .continuous (continuous),
    .avg_sel    (avg_sel),
    .period     (period),
    .trig       (trig),
    .clr_ovf    (clr_ovf),
    .soc        (soc),
    .eoc        (eoc),
    .eoc_it     (eoc_it),
    .dout       (dout),
    .data       (data),
    .valid      (valid),
    .pop        (pop),
    .busy       (busy),
    .done_it    (done_it),
    .overflow   (overflow)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ADC: goes busy after seeing soc, reports LAT cycles later.
  initial begin
    eoc = 1'b1;
    eoc_it = 1'b0;
    dout = '0;
    forever begin
      tick();
      eoc_it = 1'b0;
      if (!adc_busy) begin
        if (soc === 1'b1) begin
          adc_busy = 1;
          eoc = 1'b0;
          lat = LAT;
        end
      end else begin
        lat--;
        if (lat == 0) begin
          eoc_it = 1'b1;
          eoc = 1'b1;
          dout = adc_q.size() > 0 ? adc_q.pop_front() : '0;
          adc_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (soc === 1'b1 && soc_q !== 1'b1) soc_rises++;
    if (done_it === 1'b1) done_cnt++;
    soc_q = soc;
  end

  // Scoreboard: group samples into 2^mavg averages, track FIFO.
  always @(negedge clk) begin : mdl
    bit cap, exp_done, mdrop;
    logic [N-1:0] pv, hd;
    if (chk_on) begin
      exp_done = 0;
      mdrop = 0;
      pv = '0;
      cap = m_prev_it && live && (enable === 1'b1);
      if (cap) begin
        msum += int'(dout);
        mcnt++;
        if (mcnt == (1 << mavg)) begin
          exp_done = 1;
          pv = N'(msum >> mavg);
          msum = 0;
          mcnt = 0;
        end
      end
      hd = mq.size() > 0 ? mq[0] : '0;
      check("done_it", done_it, exp_done);
      check("valid", valid, mq.size() > 0);
      check("data", data, hd);
      check("overflow", overflow, m_ovf);
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (exp_done) begin
        if (mq.size() < DEPTH) mq.push_back(pv);
        else mdrop = 1;
      end
      if (mdrop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (!enable) begin
        msum = 0;
        mcnt = 0;
      end
      if (rst) begin
        mq.delete();
        m_ovf = 0;
        msum = 0;
        mcnt = 0;
      end
    end
    m_prev_it = eoc_it;
  end

  task automatic wait_idle(input int max);
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && !adc_busy) ok = 1;
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic pop_n(input int n);
    tick();
    pop = 1'b1;
    repeat (n) tick();
    pop = 1'b0;
  endtask

  // Trig in cycle t puts CAPTURE at t+5; pop/clr land there.
  task automatic shot(input logic [N-1:0] v, input bit dp, input bit dc);
    adc_q.push_back(v);
    tick(); trig = 1'b1;
    tick(); trig = 1'b0;
    repeat (4) tick();
    pop = dp;
    clr_ovf = dc;
    tick();
    pop = 1'b0;
    clr_ovf = 1'b0;
    wait_idle(40);
  endtask

  task automatic meas_gap(input int exp);
    bit ok = 0;
    int n = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (done_it === 1'b1) ok = 1;
    end
    check("gap_done_seen", ok, 1);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (soc === 1'b1) ok = 1;
    end
    check("gap_soc_seen", ok, 1);
    check("gap_len", n - 1, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; continuous = 1'b0;
    trig = 1'b0; clr_ovf = 1'b0; pop = 1'b0;
    avg_sel = 2'd0; period = 8'd0;
    tick();
    chk_on = 1;
    tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_soc", soc, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    tick();
    rst = 1'b0;
    enable = 1'b1;

    // single shot, with a trig during WAIT_EOC that must be dropped
    s0 = soc_rises; d0 = done_cnt;
    adc_q.push_back(8'hA5);
    tick(); trig = 1'b1;
    tick(); trig = 1'b0;
    tick();
    tick(); trig = 1'b1;
    tick(); trig = 1'b0;
    wait_idle(60);
    repeat (8) tick();
    @(negedge clk);
    check("single_soc", soc_rises - s0, 1);
    check("single_done", done_cnt - d0, 1);
    check("single_data", data, 8'hA5);
    check("single_valid", valid, 1);
    check("single_busy", busy, 0);
    pop_n(1);
    @(negedge clk);
    check("single_popped", valid, 0);

    // average of four, avg_sel changed mid-sequence must not matter
    s0 = soc_rises; d0 = done_cnt;
    avg_sel = 2'd2; mavg = 2;
    adc_q.push_back(8'd10); adc_q.push_back(8'd11);
    adc_q.push_back(8'd12); adc_q.push_back(8'd14);
    tick(); trig = 1'b1;
    tick(); trig = 1'b0; avg_sel = 2'd0;
    wait_idle(200);
    check("avg_soc", soc_rises - s0, 4);
    check("avg_done", done_cnt - d0, 1);
    check("avg_data", data, 8'd11);
    mavg = 0;
    pop_n(1);

    // free-run: gap of 5, then back-to-back
    d0 = done_cnt;
    for (int i = 1; i <= 4; i++) adc_q.push_back(N'(i));
    tick(); period = 8'd5; continuous = 1'b1;
    meas_gap(5);
    meas_gap(5);
    tick(); period = 8'd0;
    meas_gap(0);
    tick(); continuous = 1'b0;
    wait_idle(100);
    check("cont_done", done_cnt - d0, 4);
    check("cont_data", data, 8'd1);
    pop_n(5);

    // overflow, push+pop when full, clr_ovf precedence
    for (int v = 21; v <= 25; v++) shot(N'(v), 0, 0);
    check("ovf_set", overflow, 1);
    check("ovf_head", data, 8'd21);
    shot(8'd26, 1, 0);
    check("pp_head", data, 8'd22);
    check("pp_ovf", overflow, 1);
    tick(); clr_ovf = 1'b1;
    tick(); clr_ovf = 1'b0;
    @(negedge clk);
    check("clr_alone", overflow, 0);
    shot(8'd27, 0, 1);
    check("clr_vs_set", overflow, 1);
    tick(); clr_ovf = 1'b1;
    tick(); clr_ovf = 1'b0;
    @(negedge clk);
    check("clr_after", overflow, 0);
    check("order_head", data, 8'd22);
    pop_n(5);
    @(negedge clk);
    check("drained", valid, 0);

    // enable dropped in WAIT_EOC; the late eoc_it must not push
    d0 = done_cnt;
    adc_q.push_back(8'h31);
    tick(); trig = 1'b1;
    tick(); trig = 1'b0;
    tick();
    tick(); enable = 1'b0; live = 0;
    @(negedge clk);
    check("abort_busy_pre", busy, 1);
    tick();
    @(negedge clk);
    check("abort_soc", soc, 0);
    check("abort_busy", busy, 0);
    repeat (6) tick();
    @(negedge clk);
    check("abort_valid", valid, 0);
    check("abort_done", done_cnt - d0, 0);
    tick(); enable = 1'b1; live = 1;

    // reset during WAIT_BUSY with a full FIFO and overflow set
    for (int v = 41; v <= 45; v++) shot(N'(v), 0, 0);
    check("pre_rst_ovf", overflow, 1);
    tick(); trig = 1'b1;
    tick(); trig = 1'b0;
    tick(); rst = 1'b1; live = 0;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("mrst_soc", soc, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done_it, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_valid", valid, 0);
    check("mrst_data", data, 0);
    wait_idle(40);
    repeat (3) tick();
    @(negedge clk);
    check("late_it_valid", valid, 0);
    check("late_it_busy", busy, 0);
    live = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
